// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator with PC-relative target behind a 2-entry skid buffer
module imm_gen_pipe #(
  parameter int XLEN      = 32,
  parameter int IMM_SRC_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [IMM_SRC_W-1:0] in_imm_src,
  input  logic [XLEN-1:0]      in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_imm,
  output logic [XLEN-1:0]      out_target,
  output logic                 out_illegal,
  output logic [31:0]          out_instr
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state, state_nx;
  logic rdy_q, acc, drn, ill, zx;
  logic [2:0] sel;
  logic [31:0] i32, shamt, m_instr, s_instr;
  logic [XLEN-1:0] imm, tgt, m_imm, m_tgt, s_imm, s_tgt;
  logic m_ill, s_ill;
  always_comb begin
    sel   = in_imm_src[2:0];
    ill   = in_imm_src > IMM_SRC_W'(6);
    shamt = XLEN == 64 ? {26'b0, in_instr[25:20]} : {27'b0, in_instr[24:20]};
    i32   = ill       ? 32'b0 :
            sel == 0  ? {{20{in_instr[31]}}, in_instr[31:20]} :
            sel == 1  ? {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]} :
            sel == 2  ? {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0} :
            sel == 3  ? {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0} :
            sel == 4  ? {in_instr[31:12], 12'b0} :
            sel == 5  ? shamt :
            sel == 6  ? {27'b0, in_instr[19:15]} : 32'b0;
    // shamt and zimm are zero-extended; every other format sign-extends bit 31 of i32
    zx    = ill || sel == 5 || sel == 6;
    imm   = zx ? XLEN'(i32) : XLEN'($signed(i32));
    tgt   = in_pc + imm;
    acc   = in_valid & rdy_q;
    drn   = out_valid & out_ready;
  end
  always_comb begin
    state_nx = flush          ? EMPTY :
               state == EMPTY ? (acc ? ONE : EMPTY) :
               state == ONE   ? (acc == drn ? ONE : acc ? TWO : EMPTY) :
                                (drn ? ONE : TWO);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      rdy_q <= 1'b1;
    end else begin
      state <= state_nx;
      rdy_q <= state_nx != TWO;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      m_imm   <= '0;
      m_tgt   <= '0;
      m_ill   <= 1'b0;
      m_instr <= '0;
      s_imm   <= '0;
      s_tgt   <= '0;
      s_ill   <= 1'b0;
      s_instr <= '0;
    end else begin
      if (acc && (state == EMPTY || drn)) begin
        m_imm   <= imm;
        m_tgt   <= tgt;
        m_ill   <= ill;
        m_instr <= in_instr;
      end else if (drn && state == TWO) begin
        m_imm   <= s_imm;
        m_tgt   <= s_tgt;
        m_ill   <= s_ill;
        m_instr <= s_instr;
      end
      if (acc && state == ONE && !drn) begin
        s_imm   <= imm;
        s_tgt   <= tgt;
        s_ill   <= ill;
        s_instr <= in_instr;
      end
    end
  end
  always_comb begin
    out_valid   = state != EMPTY;
    in_ready    = rdy_q;
    out_imm     = m_imm;
    out_target  = m_tgt;
    out_illegal = m_ill;
    out_instr   = m_instr;
  end
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Registered, parametrised immediate-generation stage for the decode path of the pipelined core.
- Accepts an instruction, an immediate-select code and a PC over a valid/ready handshake.
- Produces the XLEN-wide immediate, the PC-relative target (pc + imm) and an illegal-select flag.
- Output is held in a 2-entry skid buffer, so stalls from execute never create a combinational ready path back to fetch.

Parameters:
- XLEN, 32, datapath width (32 or 64); immediates sign- or zero-extended to XLEN.
- IMM_SRC_W, 3, width of the immediate-select code.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous reset, active-high
- flush  input  1  discard all buffered entries (branch mispredict)
- in_valid  input  1  upstream entry valid
- in_ready  output  1  stage can accept; registered
- in_instr  input  32  instruction word
- in_imm_src  input  IMM_SRC_W  immediate select
- in_pc  input  XLEN  PC of the instruction
- out_valid  output  1  output entry valid
- out_ready  input  1  downstream accepts
- out_imm  output  XLEN  generated immediate
- out_target  output  XLEN  in_pc + imm, modulo 2^XLEN
- out_illegal  output  1  select code was reserved
- out_instr  output  32  instruction passed through

Behaviour:
- Reset: clk and rst only; synchronous, active-high.
  - During rst: out_valid=0, out_imm=0, out_target=0, out_illegal=0, out_instr=0, skid empty, in_ready=1 from the first cycle after rst deasserts.
  - rst mid-operation drops all entries; nothing is emitted afterwards.
- Select encodings (sx = sign-extend from instr[31] to XLEN):
  - 000 I: sx(instr[31:20])
  - 001 S: sx({instr[31:25], instr[11:7]})
  - 010 B: sx({instr[31], instr[7], instr[30:25], instr[11:8], 0})
  - 011 J: sx({instr[31], instr[19:12], instr[20], instr[30:21], 0})
  - 100 U: sx({instr[31:12], 12'b0})
  - 101 SHAMT: zero-extended instr[24:20] when XLEN=32; instr[25:20] when XLEN=64
  - 110 CSR zimm: zero-extended instr[19:15]
  - 111 reserved: imm=0, target=pc, out_illegal=1
- Datapath: imm and target are computed combinationally from the inputs and captured at acceptance. Target adder is XLEN wide; carry-out is discarded.
- Handshake:
  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
  - Inputs are sampled only on a transfer-in edge.
  - Outputs are stable while out_valid & !out_ready.
- Latency: 1 cycle from accept to out_valid when the buffer is empty. Throughput is 1 per cycle with out_ready held high.
- Skid buffer states (main entry drives outputs, skid entry holds overflow):
  - EMPTY: accept -> ONE.
  - ONE:
    - accept & drain -> ONE (main reloaded)
    - accept & !drain -> TWO (new entry to skid)
    - drain & !accept -> EMPTY
  - TWO: in_ready=0; drain -> ONE (skid moves to main same edge).
  - in_ready = !(state==TWO), as a registered value. No input-to-in_ready combinational path.
- Ordering: strict FIFO; the skid entry is never emitted before the main entry.
- flush:
  - Next edge goes to EMPTY: out_valid=0, in_ready=1.
  - An input transfer on the flush cycle is discarded.
  - Output data registers may keep stale values; they are qualified by out_valid.
  - flush together with rst: rst wins, with the same effect.
- Simultaneous accept and drain in ONE: no bubble, no duplication, no loss.

Test Plan:
- Reset: hold rst 3 cycles, then release -> out_valid=0, out_imm=0, in_ready=1 on first post-reset cycle.
- Encodings, XLEN=32, pc=0x100, out_ready=1, each result 1 cycle later:
  - 0xFFF00093 sel 000 -> imm 0xFFFFFFFF, target 0x000000FF
  - 0xFE000EE3 sel 010 -> imm 0xFFFFFFFC, target 0x000000FC
  - 0x008000EF sel 011 -> imm 0x00000008, target 0x00000108
  - 0x12345037 sel 100 -> imm 0x12345000
  - 0x01F0D093 sel 101 -> imm 0x0000001F
  - any instruction, sel 111 -> imm 0, target 0x100, out_illegal=1
- Backpressure:
  - Stream A, B, C with out_ready=0 -> A held, B in skid, in_ready=0 after B, C not accepted.
  - Raise out_ready -> A, B, C emitted in order, with no duplicates and no drops.
- Full throughput: 16 back-to-back entries with out_ready=1 -> 16 outputs on consecutive cycles, in_ready constantly 1.
- Flush:
  - With two entries buffered, assert flush while in_valid=1 -> next cycle out_valid=0, in_ready=1.
  - The flushed-cycle input never appears on the output.
- XLEN=64 instance: 0xFFF00093 sel 000 -> imm 0xFFFFFFFFFFFFFFFF; sel 101 with instr[25:20]=0x3F -> imm 0x3F.
